// File: rtl/elevator_pkg.sv
// Shared encodings for the four-floor car controller: floors, travel
// direction and the controller state enum.
package elevator_pkg;

   localparam logic [1:0] FLOOR1 = 2'b00;
   localparam logic [1:0] FLOOR2 = 2'b01;
   localparam logic [1:0] FLOOR3 = 2'b10;
   localparam logic [1:0] FLOOR4 = 2'b11;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      CHECK,
      DOOR
   } state_t;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter: load arms it with TICKS, done pulses on the last
// of those TICKS cycles, then it rests at zero until loaded again.
module tick_timer #(
   parameter int TICKS = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic done
);

   localparam int W = $clog2(TICKS + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(TICKS);
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == W'(1));

endmodule

// File: rtl/elevator_ctrl.sv
// Car-motion controller for a four-floor elevator: picks a direction from
// the latched requests, times floor-to-floor travel and door dwell.
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int MOVE_TICKS = 50,
   parameter int DOOR_TICKS = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       E1U,
   input  logic       E2U,
   input  logic       E2D,
   input  logic       E3U,
   input  logic       E3D,
   input  logic       E4D,
   input  logic       E1,
   input  logic       E2,
   input  logic       E3,
   input  logic       E4,
   output logic [1:0] position,
   output logic       head,
   output logic       empty,
   output logic       door,
   output logic       moving
);

   state_t     state, state_n;
   logic [1:0] pos_n;
   logic       head_n;

   logic [3:0] car_req, up_req, dn_req, any_req;
   logic [3:0] above_mask, below_mask;
   logic       req_above, req_below, ahead, behind, here, stop;
   logic       move_load, move_done, door_load, door_done;

   // Floor 1 has no down button and floor 4 no up button.
   assign car_req = {E4, E3, E2, E1};
   assign up_req  = {1'b0, E3U, E2U, E1U};
   assign dn_req  = {E4D, E3D, E2D, 1'b0};
   assign any_req = car_req | up_req | dn_req;

   // Masks select floors strictly above / below; at an end floor the
   // corresponding mask is empty, so ahead can never point past it.
   assign above_mask = 4'b1110 << position;
   assign below_mask = ~(4'b1111 << position);
   assign req_above  = |(any_req & above_mask);
   assign req_below  = |(any_req & below_mask);

   assign ahead  = head ? req_above : req_below;
   assign behind = head ? req_below : req_above;
   assign here   = any_req[position];
   assign stop   = car_req[position]
                 | (head ? up_req[position] : dn_req[position])
                 | ((head ? dn_req[position] : up_req[position]) & ~ahead);

   tick_timer #(.TICKS(MOVE_TICKS)) u_move_timer (
      .clk  (clk),
      .rst  (rst),
      .load (move_load),
      .done (move_done)
   );

   tick_timer #(.TICKS(DOOR_TICKS)) u_door_timer (
      .clk  (clk),
      .rst  (rst),
      .load (door_load),
      .done (door_done)
   );

   always_comb begin
      state_n   = state;
      pos_n     = position;
      head_n    = head;
      move_load = 1'b0;
      door_load = 1'b0;
      case (state)
         IDLE: begin
            if (here) begin
               state_n   = DOOR;
               door_load = 1'b1;
            end else if (ahead) begin
               state_n   = MOVE;
               move_load = 1'b1;
            end else if (behind) begin
               head_n    = ~head;
               state_n   = MOVE;
               move_load = 1'b1;
            end
         end
         MOVE: begin
            if (move_done) begin
               pos_n   = (head == DIR_UP) ? position + 2'd1 : position - 2'd1;
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (stop) begin
               state_n   = DOOR;
               door_load = 1'b1;
            end else if (ahead) begin
               state_n   = MOVE;
               move_load = 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         DOOR: begin
            if (door_done) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // empty is registered to break the loop through the button block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         position <= FLOOR1;
         head     <= DIR_UP;
         empty    <= 1'b1;
         door     <= 1'b0;
         moving   <= 1'b0;
      end else begin
         state    <= state_n;
         position <= pos_n;
         head     <= head_n;
         empty    <= ~ahead;
         door     <= (state_n == DOOR);
         moving   <= (state_n == MOVE);
      end
   end

endmodule
